pin_verifier: RTL and testbench

//  Consumes the Master PIN held by the PIN storage register and checks

---
 rtl/alarm_pkg.sv | 14 +
 rtl/pin_verifier_lockout_timer.sv | 36 +++
 rtl/pin_verifier.sv | 148 ++++++++++++++
 tb/tb_pin_verifier.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types for the alarm PIN path: PIN width and verifier FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

  localparam int PIN_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

endpackage

// File: rtl/pin_verifier_lockout_timer.sv
// Loadable down-counter that times the PIN lockout window.
// Latency: load takes effect on the next edge; o_expired is combinational from the count.
// Backpressure: none; counts down every cycle until it rests at zero.
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   load            load load_val this cycle (wins over decrement)
//   load_val        value to load
//   o_expired       count is zero
import alarm_pkg::*;

module lockout_timer #(
  parameter int W = 26
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/pin_verifier.sv
// Compares user PIN entries against the stored Master PIN; locks out after repeated failures.
// Latency: result pulse exactly 2 cycles after the cycle the submit rising edge is seen.
// Backpressure: submit edges arriving outside IDLE are dropped, never queued.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_submit         debounced submit button level
//   i_sw_val         PIN entry from switches
//   i_stored_pin     Master PIN from the storage register
//   o_pin_ok         1-cycle pulse, entry matched
//   o_pin_fail       1-cycle pulse, entry mismatched
//   o_locked         lockout active (level)
//   o_fail_cnt       consecutive-failure count, saturates at MAX_TRIES
//   o_busy           FSM not in IDLE
import alarm_pkg::*;

module pin_verifier #(
  parameter  int PIN_W       = alarm_pkg::PIN_W,
  parameter  int MAX_TRIES   = 3,
  parameter  int LOCK_CYCLES = 50_000_000,
  localparam int CNT_W       = $clog2(MAX_TRIES + 1),
  localparam int TMR_W       = $clog2(LOCK_CYCLES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_submit,
  input  logic [PIN_W-1:0] i_sw_val,
  input  logic [PIN_W-1:0] i_stored_pin,
  output logic             o_pin_ok,
  output logic             o_pin_fail,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TRIES);
  // Count value at which one more mismatch triggers lockout.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TRIES - 1);
  localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_CYCLES - 1);

  state_t             r_state;
  logic               r_submit_q;
  logic [PIN_W-1:0]   r_entry;
  logic               r_pin_ok;
  logic               r_pin_fail;
  logic               r_locked;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [PIN_W-1:0]   w_entry_nxt;
  logic               w_pin_ok_nxt;
  logic               w_pin_fail_nxt;
  logic               w_locked_nxt;
  logic [CNT_W-1:0]   w_fail_cnt_nxt;
  logic               w_tmr_load;
  logic               w_tmr_expired;
  logic               w_sub_rise;

  // Edge register resets to 0, so a button held through reset release counts as a press.
  assign w_sub_rise = i_submit & ~r_submit_q;

  lockout_timer #(
    .W(TMR_W)
  ) u_lockout_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .load      (w_tmr_load),
    .load_val  (LOCK_LD),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_submit_q <= 1'b0;
      r_entry    <= '0;
      r_pin_ok   <= 1'b0;
      r_pin_fail <= 1'b0;
      r_locked   <= 1'b0;
      r_fail_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_submit_q <= i_submit;
      r_entry    <= w_entry_nxt;
      r_pin_ok   <= w_pin_ok_nxt;
      r_pin_fail <= w_pin_fail_nxt;
      r_locked   <= w_locked_nxt;
      r_fail_cnt <= w_fail_cnt_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_entry_nxt    = r_entry;
    w_pin_ok_nxt   = 1'b0;
    w_pin_fail_nxt = 1'b0;
    w_locked_nxt   = r_locked;
    w_fail_cnt_nxt = r_fail_cnt;
    w_tmr_load     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sub_rise) begin
          w_entry_nxt = i_sw_val;
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        // Stored PIN is sampled here, not at latch time.
        if (r_entry == i_stored_pin) begin
          w_pin_ok_nxt   = 1'b1;
          w_fail_cnt_nxt = '0;
          w_state_nxt    = IDLE;
        end else if (r_fail_cnt < LAST_CNT) begin
          w_pin_fail_nxt = 1'b1;
          w_fail_cnt_nxt = r_fail_cnt + 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_pin_fail_nxt = 1'b1;
          w_fail_cnt_nxt = MAX_CNT;
          w_locked_nxt   = 1'b1;
          w_tmr_load     = 1'b1;
          w_state_nxt    = LOCKOUT;
        end
      end
      LOCKOUT: begin
        // Timer at zero marks the last locked cycle.
        if (w_tmr_expired) begin
          w_locked_nxt   = 1'b0;
          w_fail_cnt_nxt = '0;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_pin_ok   = r_pin_ok;
  assign o_pin_fail = r_pin_fail;
  assign o_locked   = r_locked;
  assign o_fail_cnt = r_fail_cnt;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_pin_verifier.sv
// Self-checking bench for pin_verifier: directed scenarios plus random stimulus
// against a schedule-based reference model.
// Inputs driven on the falling edge; outputs compared 1 time unit after the rising edge.
module tb_pin_verifier;

  localparam int LC    = 8;
  localparam int MT    = 3;
  localparam int NEXP  = 8192;
  localparam logic [3:0] PIN = 4'hA;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_submit;
  logic [3:0] i_sw_val;
  logic [3:0] i_stored_pin;
  logic       o_pin_ok, o_pin_fail, o_locked, o_busy;
  logic [1:0] o_fail_cnt;

  pin_verifier #(.PIN_W(4), .MAX_TRIES(MT), .LOCK_CYCLES(LC)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_submit     (i_submit),
    .i_sw_val     (i_sw_val),
    .i_stored_pin (i_stored_pin),
    .o_pin_ok     (o_pin_ok),
    .o_pin_fail   (o_pin_fail),
    .o_locked     (o_locked),
    .o_fail_cnt   (o_fail_cnt),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Expected outputs per cycle index.
  bit exp_ok     [NEXP];
  bit exp_fail   [NEXP];
  bit exp_locked [NEXP];
  int exp_cnt    [NEXP];
  bit exp_busy   [NEXP];

  // Reference model state: the block accepts a press at cycle k only if k >= m_free_at.
  bit         m_prev_sub;
  bit         m_pend;
  int         m_pend_at;
  logic [3:0] m_entry;
  int         m_cnt;
  int         m_free_at;
  int         m_sched;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic set_exp(input int k, input bit ok, input bit fl, input bit lk, input int cnt, input bit bz);
    if (k < NEXP) begin
      exp_ok[k] = ok; exp_fail[k] = fl; exp_locked[k] = lk; exp_cnt[k] = cnt; exp_busy[k] = bz;
    end
  endtask

  task automatic model_reset();
    m_prev_sub = 1'b0;
    m_pend     = 1'b0;
    m_cnt      = 0;
    m_free_at  = cyc;
    m_sched    = 0;
  endtask

  // Called once per cycle with that cycle's inputs; fills expectations for later cycles.
  task automatic model_cycle();
    int  k;
    bit  rise;
    k    = cyc;
    rise = i_submit && !m_prev_sub;
    m_prev_sub = i_submit;
    if (m_pend && k == m_pend_at + 1) begin
      m_pend = 1'b0;
      if (m_entry == i_stored_pin) begin
        m_cnt = 0;
        set_exp(k + 1, 1, 0, 0, 0, 0);
        m_free_at = k + 1; m_sched = k + 2;
      end else if (m_cnt + 1 < MT) begin
        m_cnt = m_cnt + 1;
        set_exp(k + 1, 0, 1, 0, m_cnt, 0);
        m_free_at = k + 1; m_sched = k + 2;
      end else begin
        for (int j = 0; j < LC; j++) set_exp(k + 1 + j, 0, (j == 0), 1, MT, 1);
        m_cnt = 0;
        m_free_at = k + 1 + LC; m_sched = k + 1 + LC;
      end
    end else if (rise && !m_pend && k >= m_free_at) begin
      m_pend = 1'b1; m_pend_at = k; m_entry = i_sw_val;
      set_exp(k + 1, 0, 0, 0, m_cnt, 1);
      m_sched = k + 2;
    end
    if (k + 1 >= m_sched) set_exp(k + 1, 0, 0, 0, m_cnt, 0);
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (chk_en && cyc < NEXP) begin
      chk("ok",     {31'd0, o_pin_ok},   {31'd0, exp_ok[cyc]});
      chk("fail",   {31'd0, o_pin_fail}, {31'd0, exp_fail[cyc]});
      chk("locked", {31'd0, o_locked},   {31'd0, exp_locked[cyc]});
      chk("cnt",    {30'd0, o_fail_cnt}, exp_cnt[cyc]);
      chk("busy",   {31'd0, o_busy},     {31'd0, exp_busy[cyc]});
    end
  end

  task automatic step(input bit sub, input logic [3:0] sw, input logic [3:0] pin);
    @(negedge clk);
    i_submit = sub; i_sw_val = sw; i_stored_pin = pin;
    model_cycle();
  endtask

  // Asynchronous reset mid-cycle; checks pre-reset busy/locked and immediate clear.
  task automatic do_reset(input bit pre_busy, input bit pre_locked, input bit rel_sub);
    @(posedge clk);
    #3;
    chk("pre_rst_busy",   {31'd0, o_busy},   {31'd0, pre_busy});
    chk("pre_rst_locked", {31'd0, o_locked}, {31'd0, pre_locked});
    i_rst_n = 1'b0; chk_en = 1'b0;
    #1;
    chk("rst_ok",     {31'd0, o_pin_ok},   0);
    chk("rst_fail",   {31'd0, o_pin_fail}, 0);
    chk("rst_locked", {31'd0, o_locked},   0);
    chk("rst_cnt",    {30'd0, o_fail_cnt}, 0);
    chk("rst_busy",   {31'd0, o_busy},     0);
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_submit = rel_sub; i_sw_val = PIN; i_stored_pin = PIN;
    model_reset();
    model_cycle();
    chk_en = 1'b1;
  endtask

  int nlock, npulse, nok;
  logic [3:0] seq3 [3];
  logic [3:0] rsw, rpin;
  bit rsub;

  initial begin
    i_rst_n = 1'b0; i_submit = 1'b0; i_sw_val = 4'h0; i_stored_pin = PIN;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    model_reset();
    model_cycle();
    chk_en = 1'b1;

    // Correct PIN: ok exactly two cycles after the press.
    step(1, PIN, PIN);
    step(0, 4'h0, PIN);
    chk("t2_ok_n1", {31'd0, o_pin_ok}, 0);
    chk("t2_busy_n1", {31'd0, o_busy}, 1);
    step(0, 4'h0, PIN);
    chk("t2_ok_n2", {31'd0, o_pin_ok}, 1);
    chk("t2_cnt_n2", {30'd0, o_fail_cnt}, 0);
    step(0, 4'h0, PIN);
    chk("t2_ok_n3", {31'd0, o_pin_ok}, 0);

    // fail, fail, ok: count 1, 2, 0.
    seq3[0] = 4'h3; seq3[1] = 4'h5; seq3[2] = PIN;
    for (int i = 0; i < 3; i++) begin
      step(1, seq3[i], PIN);
      step(0, 4'h0, PIN);
      step(0, 4'h0, PIN);
      chk("t3_fail", {31'd0, o_pin_fail}, (i < 2) ? 1 : 0);
      chk("t3_ok",   {31'd0, o_pin_ok},   (i == 2) ? 1 : 0);
      chk("t3_cnt",  {30'd0, o_fail_cnt}, (i == 0) ? 1 : (i == 1) ? 2 : 0);
      chk("t3_lock", {31'd0, o_locked},   0);
    end

    // Three wrong entries -> lockout for LC cycles; correct press while locked is dropped.
    seq3[0] = 4'h1; seq3[1] = 4'h2; seq3[2] = 4'h3;
    for (int i = 0; i < 3; i++) begin
      step(1, seq3[i], PIN);
      step(0, 4'h0, PIN);
      step(0, 4'h0, PIN);
    end
    chk("t4_fail3", {31'd0, o_pin_fail}, 1);
    chk("t4_lock_rise", {31'd0, o_locked}, 1);
    chk("t4_cnt_sat", {30'd0, o_fail_cnt}, 3);
    nlock = 1; npulse = 0;
    for (int i = 0; i < 30; i++) begin
      step((i == 2), PIN, PIN);
      if (o_locked) nlock++;
      if (o_pin_ok || o_pin_fail) npulse++;
    end
    chk("t4_lock_len", nlock, LC);
    chk("t5_no_pulse", npulse, 0);
    chk("t4_cnt_after", {30'd0, o_fail_cnt}, 0);

    // Held submit gives exactly one compare.
    nok = 0;
    for (int i = 0; i < 25; i++) begin
      step((i < 20), PIN, PIN);
      if (o_pin_ok) nok++;
    end
    chk("t6_hold_one", nok, 1);

    // Toggle right after a press; model tracks which edges land in IDLE.
    step(1, 4'h7, PIN); step(0, 4'h0, PIN); step(1, PIN, PIN); step(0, PIN, PIN);
    repeat (4) step(0, 4'h0, PIN);

    // Reset while in CHECK.
    step(1, PIN, PIN);
    do_reset(1, 0, 0);
    repeat (4) step(0, 4'h0, PIN);
    chk("t1_no_ok_after_rst", {31'd0, o_pin_ok}, 0);

    // Reset in lockout, with submit held across release (counts as a press).
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h0, PIN); step(0, 4'h0, PIN); step(0, 4'h0, PIN);
    end
    step(0, 4'h0, PIN);
    do_reset(1, 1, 1);
    step(1, PIN, PIN);
    step(1, PIN, PIN);
    chk("held_rel_ok", {31'd0, o_pin_ok}, 1);

    // Random phase.
    rsub = 1'b0; rpin = PIN;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 2) == 0) rsub = ~rsub;
      if ($urandom_range(0, 9) == 0) rpin = ($urandom_range(0, 1) == 0) ? PIN : 4'($urandom_range(0, 15));
      rsw = ($urandom_range(0, 2) == 0) ? rpin : 4'($urandom_range(0, 15));
      step(rsub, rsw, rpin);
    end
    repeat (LC + 4) step(0, 4'h0, rpin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
